// File: rtl/bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter
//
// Shared, iterative binary-to-BCD converter. NREQ requesters compete for the
// engine through a round-robin arbiter. The engine converts one 8-bit unsigned
// operand into three BCD digits with the shift-and-add-3 method, one bit per
// clock, and then holds the result until the consumer takes it.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester request valid
//   req_data   in   [NREQ*8]   packed operands, requester k at [8k+7:8k]
//   req_ready  out  [NREQ]     one-hot accept (combinational, IDLE only)
//   out_valid  out  result valid (registered)
//   out_ready  in   consumer accepts the result
//   out_bcd2   out  hundreds digit (registered)
//   out_bcd1   out  tens digit (registered)
//   out_bcd0   out  ones digit (registered)
//   out_id     out  [ID_W]     index of the requester owning the result
//   busy       out  high while converting or holding a result
// -----------------------------------------------------------------------------
module bcd_convert_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_bcd2,
    output logic [3:0]          out_bcd1,
    output logic [3:0]          out_bcd0,
    output logic [ID_W-1:0]     out_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Add 3 to a digit that would become >= 10 after the next doubling.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // One double-dabble step: adjust all digits, then shift {digits, bin}
    // left so the binary MSB enters the ones digit. The hundreds MSB that
    // falls off is always zero for 8-bit operands.
    function automatic logic [19:0] dd_step(input logic [11:0] dig,
                                            input logic [7:0]  bin);
        logic [11:0] adj;
        logic [19:0] cat;
        adj = {add3_digit(dig[11:8]), add3_digit(dig[7:4]), add3_digit(dig[3:0])};
        cat = {adj, bin};
        return {cat[18:0], 1'b0};
    endfunction

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q,   ptr_d;
    logic [2:0]       cnt_q,   cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [11:0]      dig_q,   dig_d;
    logic [11:0]      res_q,   res_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;

    logic             any_s;
    logic [ID_W-1:0]  win_s;
    logic [ID_W-1:0]  win_nxt_s;
    logic [7:0]       win_data_s;
    logic [19:0]      step_s;

    // Round-robin search: first valid index at or after ptr, modulo NREQ.
    always_comb begin
        int idx;
        int nxt;
        idx        = 0;
        nxt        = 0;
        any_s      = 1'b0;
        win_s      = '0;
        win_nxt_s  = '0;
        win_data_s = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            idx = (idx >= NREQ) ? (idx - NREQ) : idx;
            if (!any_s && req_valid[idx]) begin
                any_s      = 1'b1;
                win_s      = ID_W'(idx);
                nxt        = (idx + 1 >= NREQ) ? 0 : idx + 1;
                win_nxt_s  = ID_W'(nxt);
                win_data_s = req_data[8*idx +: 8];
            end else begin
                any_s      = any_s;
            end
        end
    end

    // Next-state, datapath update and combinational grant.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        dig_d     = dig_q;
        res_d     = res_q;
        id_d      = id_q;
        valid_d   = valid_q;
        req_ready = '0;
        step_s    = dd_step(dig_q, shift_q);

        case (state_q)
            S_IDLE: begin
                if (any_s) begin
                    for (int k = 0; k < NREQ; k++) begin
                        req_ready[k] = (win_s == ID_W'(k));
                    end
                    // Grant is derived from req_valid, so a grant is a handshake.
                    shift_d = win_data_s;
                    dig_d   = 12'd0;
                    id_d    = win_s;
                    ptr_d   = win_nxt_s;
                    cnt_d   = 3'd0;
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CONV: begin
                dig_d   = step_s[19:8];
                shift_d = step_s[7:0];
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // Result register only changes here so outputs stay
                    // stable through DONE, IDLE and the next conversion.
                    res_d   = step_s[19:8];
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CONV;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= 3'd0;
            shift_q <= 8'd0;
            dig_q   <= 12'd0;
            res_q   <= 12'd0;
            id_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dig_q   <= dig_d;
            res_q   <= res_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_bcd2  = res_q[11:8];
    assign out_bcd1  = res_q[7:4];
    assign out_bcd0  = res_q[3:0];
    assign out_id    = id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
module tb_bcd_convert_arbiter;

    localparam int ID_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // NREQ = 2 instance
    logic [1:0]      rv2, rr2;
    logic [15:0]     rd2;
    logic            ov2, or2, busy2;
    logic [3:0]      o2_b2, o2_b1, o2_b0;
    logic [ID_W-1:0] oid2;

    // NREQ = 3 instance
    logic [2:0]      rv3, rr3;
    logic [23:0]     rd3;
    logic            ov3, or3, busy3;
    logic [3:0]      o3_b2, o3_b1, o3_b0;
    logic [ID_W-1:0] oid3;

    bcd_convert_arbiter #(.NREQ(2), .ID_W(ID_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
        .out_valid(ov2), .out_ready(or2), .out_bcd2(o2_b2), .out_bcd1(o2_b1),
        .out_bcd0(o2_b0), .out_id(oid2), .busy(busy2));

    bcd_convert_arbiter #(.NREQ(3), .ID_W(ID_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
        .out_valid(ov3), .out_ready(or3), .out_bcd2(o3_b2), .out_bcd1(o3_b1),
        .out_bcd0(o3_b0), .out_id(oid3), .busy(busy3));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } exp_t;

    exp_t sb2[$];
    exp_t sb3[$];

    function automatic exp_t model(input int id, input int v);
        exp_t e;
        e.id = 3'(id);
        e.d2 = 4'(v / 100);
        e.d1 = 4'((v / 10) % 10);
        e.d0 = 4'(v % 10);
        return e;
    endfunction

    // Wait (bounded) for a dut2 result, check latency, pop scoreboard, compare.
    task automatic collect2(input string name, input int exp_lat);
        int   lat;
        exp_t e, got;
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (ov2 !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, ov2, lat);
            return;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        got = {oid2, o2_b2, o2_b1, o2_b0};
        checks++;
        if (sb2.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: result id=%0d with empty scoreboard", name, oid2);
        end else begin
            e = sb2.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s_result: got id=%0d bcd=%0d/%0d/%0d, required id=%0d bcd=%0d/%0d/%0d",
                         name, got.id, got.d2, got.d1, got.d0, e.id, e.d2, e.d1, e.d0);
            end
        end
    endtask

    // Same for the NREQ=3 instance.
    task automatic collect3(input string name, input int exp_lat);
        int   lat;
        exp_t e, got;
        lat = 0;
        while (!ov3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (ov3 !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, ov3, lat);
            return;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        got = {oid3, o3_b2, o3_b1, o3_b0};
        checks++;
        if (sb3.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: result id=%0d with empty scoreboard", name, oid3);
        end else begin
            e = sb3.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s_result: got id=%0d bcd=%0d/%0d/%0d, required id=%0d bcd=%0d/%0d/%0d",
                         name, got.id, got.d2, got.d1, got.d0, e.id, e.d2, e.d1, e.d0);
            end
        end
    endtask

    // One request on dut2 with out_ready high; DUT must be idle on entry.
    task automatic run_one2(input int idx, input int v, input string name);
        logic [1:0] exp_rr;
        @(negedge clk);
        exp_rr      = 2'b00;
        exp_rr[idx] = 1'b1;
        rv2         = exp_rr;
        rd2[8*idx +: 8] = 8'(v);
        #1;
        checks++;
        if (rr2 !== exp_rr) begin
            failures++;
            $display("FAIL %s_ready: req_ready=%b, required %b", name, rr2, exp_rr);
        end
        sb2.push_back(model(idx, v));
        @(negedge clk);
        rv2 = 2'b00;
        checks++;
        if (busy2 !== 1'b1 || rr2 !== 2'b00) begin
            failures++;
            $display("FAIL %s_busy: busy=%b req_ready=%b, required 1/00", name, busy2, rr2);
        end
        collect2(name, 8);
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: out_valid=%b busy=%b, required 0/0", name, ov2, busy2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rv2 = '0; rd2 = '0; or2 = 1'b1;
        rv3 = '0; rd3 = '0; or3 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ov2, busy2, o2_b2, o2_b1, o2_b0, oid2} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs: v=%b busy=%b bcd=%0d/%0d/%0d id=%0d, required all 0",
                     ov2, busy2, o2_b2, o2_b1, o2_b0, oid2);
        end
        rv2 = 2'b11;
        #1;
        checks++;
        if (rr2 !== 2'b01) begin
            failures++;
            $display("FAIL reset_priority: req_ready=%b, required 01", rr2);
        end
        rv2 = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_one2(0, 255, "single255");
    endtask

    task automatic test_sweep();
        int vals[7] = '{0, 9, 10, 99, 100, 199, 200};
        foreach (vals[i]) run_one2(1, vals[i], $sformatf("sweep%0d", vals[i]));
    endtask

    task automatic test_back_to_back();
        rd2 = {8'd34, 8'd12};
        sb2.push_back(model(0, 12));
        sb2.push_back(model(1, 34));
        sb2.push_back(model(0, 12));
        sb2.push_back(model(1, 34));
        @(negedge clk);
        rv2 = 2'b11;
        for (int r = 0; r < 4; r++) begin
            collect2($sformatf("alt%0d", r), 9);
            if (r == 3) rv2 = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t hold;
        or2 = 1'b0;
        @(negedge clk);
        rv2 = 2'b01;
        rd2[7:0] = 8'd77;
        #1;
        checks++;
        if (rr2 !== 2'b01) begin
            failures++;
            $display("FAIL bp_ready: req_ready=%b, required 01", rr2);
        end
        sb2.push_back(model(0, 77));
        @(negedge clk);
        rv2 = 2'b10;
        rd2[15:8] = 8'd56;
        collect2("bp", 8);
        hold = model(0, 77);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ov2 !== 1'b1 || {oid2, o2_b2, o2_b1, o2_b0} !== hold || rr2 !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold%0d: v=%b id=%0d bcd=%0d/%0d/%0d rr=%b, required 1 id=0 0/7/7 rr=00",
                         c, ov2, oid2, o2_b2, o2_b1, o2_b0, rr2);
            end
        end
        or2 = 1'b1;
        #1;
        checks++;
        if (rr2 !== 2'b00) begin
            failures++;
            $display("FAIL bp_same_cycle: req_ready=%b, required 00", rr2);
        end
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b0 || rr2 !== 2'b10) begin
            failures++;
            $display("FAIL bp_after: out_valid=%b req_ready=%b, required 0/10", ov2, rr2);
        end
        sb2.push_back(model(1, 56));
        @(negedge clk);
        rv2 = 2'b00;
        checks++;
        if (busy2 !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept: busy=%b, required 1", busy2);
        end
        collect2("bp2", 8);
        @(negedge clk);
    endtask

    task automatic test_reset_midconv();
        @(negedge clk);
        rv2 = 2'b01;
        rd2[7:0] = 8'd200;
        @(negedge clk);
        // request accepted; requesters keep presenting while it converts
        rv2 = 2'b11;
        rd2 = {8'd34, 8'd45};
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov2, busy2, o2_b2, o2_b1, o2_b0, oid2} !== 18'd0) begin
            failures++;
            $display("FAIL midconv_reset: v=%b busy=%b bcd=%0d/%0d/%0d id=%0d, required all 0",
                     ov2, busy2, o2_b2, o2_b1, o2_b0, oid2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rr2 !== 2'b01) begin
            failures++;
            $display("FAIL midconv_ptr: req_ready=%b, required 01", rr2);
        end
        sb2.push_back(model(0, 45));
        @(negedge clk);
        rv2 = 2'b00;
        collect2("midconv", 8);
        @(negedge clk);
    endtask

    task automatic test_nreq3();
        @(negedge clk);
        rv3 = 3'b100;
        rd3[23:16] = 8'd128;
        #1;
        checks++;
        if (rr3 !== 3'b100) begin
            failures++;
            $display("FAIL n3_ready: req_ready=%b, required 100", rr3);
        end
        sb3.push_back(model(2, 128));
        @(negedge clk);
        rv3 = 3'b111;
        rd3 = {8'd128, 8'd2, 8'd1};
        collect3("n3_req2", 8);
        @(negedge clk);
        checks++;
        if (rr3 !== 3'b001) begin
            failures++;
            $display("FAIL n3_wrap: req_ready=%b, required 001", rr3);
        end
        sb3.push_back(model(0, 1));
        @(negedge clk);
        rv3 = 3'b000;
        collect3("n3_req0", 8);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_back_to_back();
        test_backpressure();
        test_reset_midconv();
        test_nreq3();
        checks++;
        if (sb2.size() != 0 || sb3.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d/%0d entries, required 0/0", sb2.size(), sb3.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
